// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video-path types and resolution constants
package video_pkg;

    localparam int NTSC_RES_H    = 720;
    localparam int VGA_RES_H_ACT = 640;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

endpackage

// File: rtl/pixel_out_reg.sv
// rtl/pixel_out_reg.sv - one-entry valid/ready output register for kept pixels
module pixel_out_reg #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_x,
    input  logic [CNT_W-1:0]  load_y,
    input  logic              load_field,
    input  logic              load_eol,
    input  logic              out_ready,
    output logic              ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_x,
    output logic [CNT_W-1:0]  out_y,
    output logic              out_field,
    output logic              out_eol
);

    // The slot is free when empty or when its occupant leaves this cycle.
    assign ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_field <= 1'b0;
            out_eol   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_x     <= load_x;
            out_y     <= load_y;
            out_field <= load_field;
            out_eol   <= load_eol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_decimator.sv
// rtl/pixel_decimator.sv - Bresenham horizontal decimator; PIXEL_DECIMATOR_STATS_EN adds line stats
module pixel_decimator
    import video_pkg::*;
#(
    parameter int DATA_W = $bits(rgb565_t),
    parameter int IN_H   = NTSC_RES_H,
    parameter int OUT_H  = VGA_RES_H_ACT,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sol,
    input  logic              in_sof,
    input  logic              in_field,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_x,
    output logic [CNT_W-1:0]  out_y,
    output logic              out_field,
`ifdef PIXEL_DECIMATOR_STATS_EN
    output logic [7:0]        short_lines,
    output logic [7:0]        long_lines,
    input  logic              stats_clr,
`endif
    output logic              out_eol
);

    localparam logic [CNT_W:0]   IN_H_V    = (CNT_W+1)'(IN_H);
    localparam logic [CNT_W:0]   OUT_H_V   = (CNT_W+1)'(OUT_H);
    localparam logic [CNT_W:0]   START_ACC = IN_H_V - OUT_H_V;
    localparam logic [CNT_W-1:0] LAST_X    = CNT_W'(OUT_H - 1);

    dec_state_t       state, state_next;
    logic [CNT_W:0]   acc, acc_next, acc_base, sum;
    logic [CNT_W-1:0] x, x_next, x_base;
    logic [CNT_W-1:0] y, y_next;
    logic             field, field_next;
    logic             first_line, first_next;
    logic             accept, process, keep;

    assign accept = in_valid & in_ready;

    always_comb begin
        state_next = state;
        acc_next   = acc;
        x_next     = x;
        y_next     = y;
        field_next = field;
        first_next = first_line;
        acc_base   = acc;
        x_base     = x;
        sum        = '0;
        process    = 1'b0;
        keep       = 1'b0;

        if (accept) begin
            if (in_sol) begin
                // A line start restarts the accumulator and is itself a candidate pixel.
                state_next = ST_ACTIVE;
                acc_base   = START_ACC;
                x_base     = '0;
                field_next = in_field;
                y_next     = (in_sof | first_line) ? '0 : y + CNT_W'(1);
                first_next = 1'b0;
                process    = 1'b1;
            end else if (state == ST_ACTIVE) begin
                process = 1'b1;
            end
        end

        if (process) begin
            sum = acc_base + OUT_H_V;
            if (sum >= IN_H_V) begin
                keep     = 1'b1;
                acc_next = sum - IN_H_V;
                x_next   = x_base + CNT_W'(1);
                if (x_base == LAST_X) begin
                    state_next = ST_DRAIN;
                end
            end else begin
                acc_next = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            acc        <= '0;
            x          <= '0;
            y          <= '0;
            field      <= 1'b0;
            first_line <= 1'b1;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            x          <= x_next;
            y          <= y_next;
            field      <= field_next;
            first_line <= first_next;
        end
    end

    pixel_out_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (keep),
        .load_data  (in_data),
        .load_x     (x_base),
        .load_y     (y_next),
        .load_field (field_next),
        .load_eol   (x_base == LAST_X),
        .out_ready  (out_ready),
        .ready      (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_field  (out_field),
        .out_eol    (out_eol)
    );

`ifdef PIXEL_DECIMATOR_STATS_EN
    logic long_seen;
    logic short_inc, long_inc;

    assign short_inc = accept & in_sol & (state == ST_ACTIVE);
    // A long line is counted once, on its first beat seen in DRAIN.
    assign long_inc  = accept & ~in_sol & (state == ST_DRAIN) & ~long_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            long_seen   <= 1'b0;
            short_lines <= '0;
            long_lines  <= '0;
        end else begin
            if (accept & in_sol) begin
                long_seen <= 1'b0;
            end else if (long_inc) begin
                long_seen <= 1'b1;
            end

            if (stats_clr) begin
                short_lines <= '0;
            end else if (short_inc && short_lines != 8'hff) begin
                short_lines <= short_lines + 8'd1;
            end

            if (stats_clr) begin
                long_lines <= '0;
            end else if (long_inc && long_lines != 8'hff) begin
                long_lines <= long_lines + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pixel_decimator.sv
// tb/tb_pixel_decimator.sv - scoreboard bench for pixel_decimator
module tb_pixel_decimator;

    localparam int DATA_W = 16;
    localparam int IN_H   = 720;
    localparam int OUT_H  = 640;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sol, in_sof, in_field;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_x, out_y;
    logic              out_field, out_eol;
`ifdef PIXEL_DECIMATOR_STATS_EN
    logic [7:0]        short_lines, long_lines;
    logic              stats_clr;
`endif

    always #5 clk = ~clk;

    pixel_decimator #(
        .DATA_W (DATA_W),
        .IN_H   (IN_H),
        .OUT_H  (OUT_H),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sol    (in_sol),
        .in_sof    (in_sof),
        .in_field  (in_field),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_field (out_field),
`ifdef PIXEL_DECIMATOR_STATS_EN
        .short_lines (short_lines),
        .long_lines  (long_lines),
        .stats_clr   (stats_clr),
`endif
        .out_eol   (out_eol)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  x;
        logic [CNT_W-1:0]  y;
        logic              field;
        logic              eol;
    } exp_t;

    exp_t              exp_q[$];
    int                n_cmp = 0, n_err = 0;
    int                n_out = 0, n_eol = 0, last_y = -1;
    logic [DATA_W-1:0] eol_data = '0;
    int                ready_mode = 0, valid_pct = 100, cyc = 0;

    // Reference model state: line-level view of the decimation rule.
    bit m_open = 0, m_first = 1, m_field = 0, m_long = 0;
    int m_idx = 0, m_kept = 0, m_y = 0, m_short_cnt = 0, m_long_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Number of pixels kept after input pixels 0..i of a line (ideal Bresenham count).
    function automatic int kept_upto(input int i);
        return ((i + 1) * OUT_H + IN_H - OUT_H) / IN_H;
    endfunction

    task automatic model_accept(input logic [DATA_W-1:0] d, input logic sol, input logic sof,
                                input logic fld);
        exp_t e;
        if (sol) begin
            if (m_open && m_kept < OUT_H && m_short_cnt < 255) m_short_cnt++;
            m_y     = (sof || m_first) ? 0 : m_y + 1;
            m_open  = 1;
            m_idx   = 0;
            m_kept  = 0;
            m_field = fld;
            m_first = 0;
            m_long  = 0;
        end
        if (!m_open) return;
        if (m_kept < OUT_H) begin
            if (kept_upto(m_idx) > kept_upto(m_idx - 1)) begin
                e.data  = d;
                e.x     = CNT_W'(m_kept);
                e.y     = CNT_W'(m_y);
                e.field = m_field;
                e.eol   = (m_kept == OUT_H - 1);
                exp_q.push_back(e);
                m_kept++;
            end
            m_idx++;
        end else if (!m_long) begin
            m_long = 1;
            if (m_long_cnt < 255) m_long_cnt++;
        end
    endtask

    task automatic set_ready();
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            2:       out_ready = ($urandom_range(0, 99) < 70);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_ready();
            in_valid = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [DATA_W-1:0] d, input logic sol, input logic sof,
                              input logic fld);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(posedge clk); #1;
            set_ready();
            in_valid = ($urandom_range(0, 99) < valid_pct);
            in_data  = d;
            in_sol   = sol;
            in_sof   = sof;
            in_field = fld;
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_accept(d, sol, sof, fld);
                done = 1;
            end
            guard++;
            if (!done && guard > 300) begin
                n_cmp++; n_err++;
                $display("FAIL beat_stuck: got in_ready=%0b expected acceptance", in_ready);
                done = 1;
            end
        end
    endtask

    task automatic send_line(input int len, input logic sof, input logic fld, input bit rnd);
        for (int i = 0; i < len; i++)
            drive_beat(rnd ? DATA_W'($urandom) : DATA_W'(i), i == 0, sof && i == 0, fld);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            idle(1);
            g++;
        end
        idle(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a transfer seen at this negedge completes at the next posedge.
    always @(negedge clk) begin : monitor
        exp_t e, a;
        if (!reset) begin
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                a = {out_data, out_x, out_y, out_field, out_eol};
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(a), 64'd0 - 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", 64'(a), 64'(e));
                end
                n_out++;
                last_y = int'(out_y);
                if (out_eol) begin
                    n_eol++;
                    eol_data = out_data;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sol = 1'b0; in_sof = 1'b0;
        in_field = 1'b0; out_ready = 1'b1;
`ifdef PIXEL_DECIMATOR_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_x",     64'(out_x),     64'd0);
        check("rst_out_y",     64'(out_y),     64'd0);
        check("rst_out_field", 64'(out_field), 64'd0);
        check("rst_out_eol",   64'(out_eol),   64'd0);

        // Single 720-pixel line, full rate.
        n_out = 0; n_eol = 0;
        send_line(720, 1, 0, 0);
        wait_drain();
        check("line_count", 64'(n_out), 64'd640);
        check("line_eols", 64'(n_eol), 64'd1);
        check("eol_data", 64'(eol_data), 64'd719);

        // Same line with out_ready high one cycle in three.
        ready_mode = 1; n_out = 0; n_eol = 0;
        send_line(720, 1, 0, 0);
        wait_drain();
        check("bp_line_count", 64'(n_out), 64'd640);
        check("bp_line_eols", 64'(n_eol), 64'd1);

        // Three lines of field 1, then a new field.
        ready_mode = 0;
        send_line(720, 1, 1, 0);
        send_line(720, 0, 1, 0);
        send_line(720, 0, 1, 0);
        wait_drain();
        check("third_line_y", 64'(last_y), 64'd2);
        send_line(720, 1, 0, 0);
        wait_drain();
        check("new_field_y", 64'(last_y), 64'd0);

        // Long line: extra pixels land in DRAIN.
        n_out = 0;
        send_line(730, 1, 0, 0);
        wait_drain();
        check("long_line_count", 64'(n_out), 64'd640);

        // Short line: 300 pixels drop indices 1,10,...,298 (34 of them).
        n_out = 0; n_eol = 0;
        send_line(300, 1, 0, 0);
        wait_drain();
        check("short_line_count", 64'(n_out), 64'd266);
        check("short_line_eols", 64'(n_eol), 64'd0);
        send_line(720, 0, 0, 0);
        wait_drain();

`ifdef PIXEL_DECIMATOR_STATS_EN
        check("stat_long", 64'(long_lines), 64'd1);
        check("stat_short", 64'(short_lines), 64'd1);
        check("model_long", 64'(m_long_cnt), 64'd1);
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        m_long_cnt = 0; m_short_cnt = 0;
        @(negedge clk);
        check("stat_clr_long", 64'(long_lines), 64'd0);
        check("stat_clr_short", 64'(short_lines), 64'd0);
`endif

        // Randomized lines with random stalls on both sides.
        valid_pct = 80; ready_mode = 2;
        for (int l = 0; l < 8; l++)
            send_line($urandom_range(200, 760), $urandom_range(0, 2) == 0,
                      1'($urandom_range(0, 1)), 1);
        wait_drain();
`ifdef PIXEL_DECIMATOR_STATS_EN
        check("rand_stat_long", 64'(long_lines), 64'(m_long_cnt));
        check("rand_stat_short", 64'(short_lines), 64'(m_short_cnt));
`endif

        // Reset while a pixel is held in the output register.
        valid_pct = 100; ready_mode = 3;
        drive_beat(16'h1234, 1, 1, 1);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        m_open = 0; m_first = 1; m_y = 0; m_short_cnt = 0; m_long_cnt = 0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data",  64'(out_data),  64'd0);
        check("mid_rst_x",     64'(out_x),     64'd0);
        check("mid_rst_y",     64'(out_y),     64'd0);
        check("mid_rst_field", 64'(out_field), 64'd0);
        check("mid_rst_eol",   64'(out_eol),   64'd0);
        ready_mode = 0; n_out = 0;
        for (int i = 0; i < 20; i++) drive_beat(DATA_W'(i + 100), 0, 0, 0);
        idle(3);
        check("idle_discard", 64'(n_out), 64'd0);
        send_line(720, 0, 1, 0);
        wait_drain();
        check("post_rst_y", 64'(last_y), 64'd0);
`ifdef PIXEL_DECIMATOR_STATS_EN
        check("post_rst_long", 64'(long_lines), 64'd0);
        check("post_rst_short", 64'(short_lines), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
